// File: rtl/dmem_arbiter.sv
// Shares one synchronous data RAM and the LED/switch registers between the CPU LSU (port 0)
// and the debug loader (port 1): round-robin arbitration plus an exclusive lock for port 1.
module dmem_arbiter #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] LED_ADDR = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] SW_ADDR  = 32'h0000_1004
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m0_ready,
  output logic              m1_ready,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [7:0]        sw,
  output logic [7:0]        leds_out
);

  typedef enum logic [0:0] {
    ST_RR   = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  state_t            state_r, state_nxt_s;
  logic              last_grant_r;
  logic [7:0]        leds_r;
  logic              tag_valid_r, tag_port_r, tag_io_r;
  logic [DATA_W-1:0] io_data_r;

  logic              lock_hold_s, arb_last_s, grant0_s, grant1_s, any_grant_s;
  logic              sel_we_s, led_hit_s, sw_hit_s, io_hit_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s, resp_data_s;

  // Arbitration and next-state; leaving LOCK arbitrates as RR with port 1 counted as last winner.
  always_comb begin
    lock_hold_s = 1'b0;
    arb_last_s  = last_grant_r;
    grant0_s    = 1'b0;
    grant1_s    = 1'b0;
    state_nxt_s = state_r;
    if (state_r == ST_LOCK) begin
      lock_hold_s = m1_lock;
      arb_last_s  = 1'b1;
    end else begin
      lock_hold_s = 1'b0;
      arb_last_s  = last_grant_r;
    end
    if (!reset) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (lock_hold_s) begin
      grant0_s = 1'b0;
      grant1_s = m1_req;
    end else if (m0_req && m1_req) begin
      grant0_s = arb_last_s;
      grant1_s = !arb_last_s;
    end else begin
      grant0_s = m0_req;
      grant1_s = m1_req;
    end
    case (state_r)
      ST_RR:   state_nxt_s = (grant1_s && m1_lock) ? ST_LOCK : ST_RR;
      ST_LOCK: state_nxt_s = m1_lock ? ST_LOCK : ST_RR;
      default: state_nxt_s = ST_RR;
    endcase
  end

  // Route the granted port and decode its word address against the I/O registers.
  always_comb begin
    any_grant_s = grant0_s | grant1_s;
    if (grant1_s) begin
      sel_we_s    = m1_we;
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
    end else begin
      sel_we_s    = m0_we;
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
    end
    led_hit_s = (sel_addr_s[ADDR_W-1:2] == LED_ADDR[ADDR_W-1:2]);
    sw_hit_s  = (sel_addr_s[ADDR_W-1:2] == SW_ADDR[ADDR_W-1:2]);
    io_hit_s  = led_hit_s | sw_hit_s;
    mem_en    = any_grant_s & !io_hit_s;
    mem_we    = mem_en & sel_we_s;
    if (mem_en) begin
      mem_addr  = sel_addr_s;
      mem_wdata = sel_wdata_s;
    end else begin
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
    end
  end

  // Read response steering from the registered tag; rdata is forced to zero without rvalid.
  always_comb begin
    resp_data_s = tag_io_r ? io_data_r : mem_rdata;
    m0_rvalid   = tag_valid_r & !tag_port_r;
    m1_rvalid   = tag_valid_r & tag_port_r;
    m0_rdata    = m0_rvalid ? resp_data_s : {DATA_W{1'b0}};
    m1_rdata    = m1_rvalid ? resp_data_s : {DATA_W{1'b0}};
  end

  assign m0_ready = grant0_s;
  assign m1_ready = grant1_s;
  assign leds_out = leds_r;

  // State, round-robin history, LED register and pending read tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_RR;
      last_grant_r <= 1'b1;
      leds_r       <= 8'h00;
      tag_valid_r  <= 1'b0;
      tag_port_r   <= 1'b0;
      tag_io_r     <= 1'b0;
      io_data_r    <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      if (any_grant_s) begin
        last_grant_r <= grant1_s;
      end
      if (any_grant_s && sel_we_s && led_hit_s) begin
        leds_r <= sel_wdata_s[7:0];
      end
      tag_valid_r <= any_grant_s & !sel_we_s;
      tag_port_r  <= grant1_s;
      tag_io_r    <= io_hit_s;
      io_data_r   <= led_hit_s ? {{(DATA_W-8){1'b0}}, leds_r} : {{(DATA_W-8){1'b0}}, sw};
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a small RAM model answers mem_* accesses one cycle later.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ready, m1_ready, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic [7:0]  sw, leds_out;
  logic [31:0] ram [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_ready(m0_ready), .m1_ready(m1_ready),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .sw(sw), .leds_out(leds_out)
  );

  // RAM model: word k holds 32'hA000_0000 + k after reset.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) ram[i] <= 32'hA000_0000 | 32'(i);
      mem_rdata <= 32'h0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      else mem_rdata <= ram[mem_addr[9:2]];
    end
  end

  task automatic test_reset();
    reset = 1'b0; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (m0_ready !== 1'b0 || mem_en !== 1'b0) begin
        errors++; $display("FAIL reset_quiet: ready=%b mem_en=%b required 0/0", m0_ready, mem_en);
      end
    end
    m0_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (leds_out !== 8'h00) begin errors++; $display("FAIL reset_leds: got %h required 00", leds_out); end
    checks++;
    if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      errors++; $display("FAIL reset_rvalid: got %b%b required 00", m0_rvalid, m1_rvalid);
    end
  endtask

  task automatic test_first_tie();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4;
    #1;
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL tie_grant: ready0=%b ready1=%b required 1/0", m0_ready, m1_ready);
    end
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL tie_mem: en=%b addr=%h required 1/00000000", mem_en, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 32'hA000_0000) begin
      errors++; $display("FAIL tie_resp0: rvalid=%b%b rdata=%h required 10/a0000000", m0_rvalid, m1_rvalid, m0_rdata);
    end
    m0_req = 1'b0;
    #1;
    checks++;
    if (m1_ready !== 1'b1) begin errors++; $display("FAIL tie_grant1: got %b required 1", m1_ready); end
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 32'hA000_0001) begin
      errors++; $display("FAIL tie_resp1: rvalid=%b%b rdata=%h required 01/a0000001", m0_rvalid, m1_rvalid, m1_rdata);
    end
    m1_req = 1'b0;
  endtask

  task automatic test_alternate();
    logic        g1;
    logic [31:0] got, other, want;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'hC;
    for (int i = 0; i < 6; i++) begin
      g1 = i[0];
      #1;
      checks++;
      if (m0_ready !== !g1 || m1_ready !== g1) begin
        errors++; $display("FAIL alt_grant[%0d]: ready=%b%b required %b%b", i, m0_ready, m1_ready, !g1, g1);
      end
      @(negedge clk);
      got   = g1 ? m1_rdata : m0_rdata;
      other = g1 ? m0_rdata : m1_rdata;
      want  = g1 ? 32'hA000_0003 : 32'hA000_0002;
      checks++;
      if (m0_rvalid !== !g1 || m1_rvalid !== g1) begin
        errors++; $display("FAIL alt_rvalid[%0d]: rvalid=%b%b required %b%b", i, m0_rvalid, m1_rvalid, !g1, g1);
      end
      checks++;
      if (got !== want || other !== 32'h0) begin
        errors++; $display("FAIL alt_rdata[%0d]: got %h/%h required %h/00000000", i, got, other, want);
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
  endtask

  task automatic test_io();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000; m0_wdata = 32'h0000_00A5;
    #1;
    checks++;
    if (m0_ready !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL led_wr: ready=%b mem_en=%b required 1/0", m0_ready, mem_en);
    end
    @(negedge clk);
    checks++;
    if (leds_out !== 8'hA5 || m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL led_val: leds=%h rvalid=%b required a5/0", leds_out, m0_rvalid);
    end
    m0_we = 1'b0;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_00A5) begin
      errors++; $display("FAIL led_rd: rvalid=%b rdata=%h required 1/000000a5", m0_rvalid, m0_rdata);
    end
    sw = 8'd99; m0_addr = 32'h1004;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL sw_mem_en: got %b required 0", mem_en); end
    @(negedge clk);
    sw = 8'd7;
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'h0000_0063) begin
      errors++; $display("FAIL sw_rd: rvalid=%b rdata=%h required 1/00000063", m0_rvalid, m0_rdata);
    end
    m0_we = 1'b1; m0_wdata = 32'h0000_00FF;
    @(negedge clk);
    checks++;
    if (leds_out !== 8'hA5 || m0_rvalid !== 1'b0) begin
      errors++; $display("FAIL sw_wr: leds=%h rvalid=%b required a5/0", leds_out, m0_rvalid);
    end
    m0_req = 1'b0; m0_we = 1'b0;
  endtask

  task automatic test_lock();
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_lock = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (m0_ready !== 1'b0 || m1_ready !== 1'b1) begin
        errors++; $display("FAIL lock_hold[%0d]: ready=%b%b required 01", i, m0_ready, m1_ready);
      end
      @(negedge clk);
    end
    m1_lock = 1'b0;
    #1;
    checks++;
    if (m0_ready !== 1'b1 || m1_ready !== 1'b0) begin
      errors++; $display("FAIL lock_release: ready=%b%b required 10", m0_ready, m1_ready);
    end
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hA000_0000) begin
      errors++; $display("FAIL lock_resp: rvalid=%b rdata=%h required 1/a0000000", m0_rvalid, m0_rdata);
    end
    m1_req = 1'b0; m1_lock = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (m0_ready !== 1'b1) begin errors++; $display("FAIL lock_nogrant: ready0=%b required 1", m0_ready); end
    @(negedge clk);
    m0_req = 1'b0; m1_lock = 1'b0;
  endtask

  task automatic test_reset_mid();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h1000; m0_wdata = 32'h0000_003C;
    @(negedge clk);
    checks++;
    if (leds_out !== 8'h3C) begin errors++; $display("FAIL mid_led: got %h required 3c", leds_out); end
    m0_we = 1'b0; m0_addr = 32'h0;
    #1;
    checks++;
    if (m0_ready !== 1'b1) begin errors++; $display("FAIL mid_grant: got %b required 1", m0_ready); end
    reset = 1'b0;
    #1;
    checks++;
    if (m0_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL mid_gate: ready=%b mem_en=%b required 0/0", m0_ready, mem_en);
    end
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0 || leds_out !== 8'h00) begin
      errors++; $display("FAIL mid_reset: rvalid=%b leds=%h required 0/00", m0_rvalid, leds_out);
    end
    m0_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_rvalid !== 1'b0) begin errors++; $display("FAIL mid_after: rvalid=%b required 0", m0_rvalid); end
  endtask

  task automatic test_ram_port1();
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (m1_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_wr: ready=%b en=%b we=%b addr=%h wdata=%h required 1/1/1/00000020/deadbeef",
                         m1_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0) begin errors++; $display("FAIL ram_wr_rvalid: got %b required 0", m1_rvalid); end
    m1_we = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
      errors++; $display("FAIL ram_rd: en=%b we=%b required 1/0", mem_en, mem_we);
    end
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL ram_rd_data: rvalid=%b rdata=%h required 1/deadbeef", m1_rvalid, m1_rdata);
    end
    m1_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin
      errors++; $display("FAIL ram_idle: rvalid=%b rdata=%h required 0/00000000", m1_rvalid, m1_rdata);
    end
  endtask

  initial begin
    reset = 1'b0; m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_lock = 1'b0;
    sw = 8'h00;
    test_reset();
    test_first_tie();
    test_alternate();
    test_io();
    test_lock();
    test_reset_mid();
    test_ram_port1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
